// File: rtl/usb_slave_rx_stream_framer.sv
// rtl/usb_slave_rx_stream_framer.sv - turns line-receiver bytes and events into the tagged PID/data/stop stream
module usb_slave_rx_stream_framer #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000,
    parameter int          MIN_GAP        = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_byte,
    input  logic       rx_byte_valid,
    input  logic       rx_sop,
    input  logic       rx_eop,
    input  logic       rx_bitstuff_err,
    input  logic       timeout_en,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    output logic [7:0] rx_stream_status,
    output logic       rx_timeout
);
    typedef enum logic [1:0] {IDLE, PAYLOAD, DISCARD, STOP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  pid_q, pid_d;
    logic [15:0] crc_q, crc_d;
    logic        bs_q, bs_d, ovr_q, ovr_d;
    logic        byte_full_q, byte_full_d, stop_full_q, stop_full_d, stop_first_q, stop_first_d;
    logic [7:0]  byte_data_q, byte_data_d, byte_stat_q, byte_stat_d, stop_data_q, stop_data_d;
    logic [7:0]  gap_q, gap_d;
    logic [7:0]  rx_data_q, rx_data_d, rx_status_q, rx_status_d;
    logic        rx_valid_q, rx_valid_d, rx_timeout_q, rx_timeout_d;
    logic [15:0] tcnt_q, tcnt_d;
    logic        fired_q, fired_d;

    logic        byte_push, stop_push, pid_ok, new_pkt;
    logic [7:0]  push_data, push_stat, stop_val;

    // Bits enter LSB first into a left-shifting register; a good packet leaves 16'h800D.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = d[i] ^ r[15];
            r  = {r[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
        end
        return r;
    endfunction

    function automatic logic [7:0] stop_flags(input logic [3:0] pid, input logic [15:0] crc,
                                              input logic bs, input logic ovr);
        logic [7:0] f;
        f    = 8'h00;
        f[0] = (pid[1:0] == 2'b11) && (crc != 16'h800D);
        f[1] = bs;
        f[2] = (pid == 4'hA);
        f[3] = ovr;
        f[5] = (pid == 4'h2);
        f[6] = (pid == 4'hB);
        return f;
    endfunction

    assign pid_ok = (rx_byte[7:4] == ~rx_byte[3:0]);

    always_comb begin
        state_d      = state_q;
        pid_d        = pid_q;
        crc_d        = crc_q;
        bs_d         = bs_q;
        ovr_d        = ovr_q;
        byte_full_d  = byte_full_q;
        byte_data_d  = byte_data_q;
        byte_stat_d  = byte_stat_q;
        stop_full_d  = stop_full_q;
        stop_data_d  = stop_data_q;
        stop_first_d = stop_first_q;
        gap_d        = (gap_q != 8'd0) ? gap_q - 8'd1 : 8'd0;
        rx_data_d    = rx_data_q;
        rx_status_d  = rx_status_q;
        rx_valid_d   = 1'b0;
        byte_push    = 1'b0;
        push_data    = rx_byte;
        push_stat    = 8'd1;
        stop_push    = 1'b0;
        stop_val     = stop_flags(pid_q, crc_q, bs_q, ovr_q);
        new_pkt      = 1'b0;

        case (state_q)
            IDLE:    new_pkt = rx_byte_valid && rx_sop;
            STOP: begin
                stop_push = 1'b1;
                state_d   = IDLE;
                new_pkt   = rx_byte_valid && rx_sop;
            end
            PAYLOAD: begin
                if (rx_byte_valid && rx_sop) begin
                    stop_push = 1'b1;
                    stop_val  = stop_flags(pid_q, crc_q, 1'b1, ovr_q);
                    new_pkt   = 1'b1;
                end else begin
                    if (rx_bitstuff_err) bs_d = 1'b1;
                    if (rx_byte_valid) begin
                        byte_push = 1'b1;
                        if (pid_q[1:0] == 2'b11) crc_d = crc16_byte(crc_q, rx_byte);
                    end
                    if (rx_eop) state_d = STOP;
                end
            end
            DISCARD: if (rx_eop) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (new_pkt) begin
            if (pid_ok) begin
                byte_push = 1'b1;
                push_stat = 8'd0;
                pid_d     = rx_byte[3:0];
                bs_d      = 1'b0;
                ovr_d     = 1'b0;
                crc_d     = 16'hFFFF;
                state_d   = PAYLOAD;
            end else begin
                state_d   = DISCARD;
            end
        end

        if (byte_push) begin
            if (byte_full_q) begin
                ovr_d = 1'b1;
            end else begin
                byte_full_d = 1'b1;
                byte_data_d = push_data;
                byte_stat_d = push_stat;
            end
        end
        // A stop that finds the byte slot empty precedes whatever byte lands alongside it (a new PID).
        if (stop_push) begin
            stop_full_d  = 1'b1;
            stop_data_d  = stop_val;
            stop_first_d = !byte_full_q;
        end

        if (gap_q == 8'd0) begin
            if (stop_full_d && (stop_first_d || !byte_full_d)) begin
                rx_valid_d  = 1'b1;
                rx_data_d   = stop_data_d;
                rx_status_d = 8'd2;
                stop_full_d = 1'b0;
                gap_d       = 8'(MIN_GAP - 1);
            end else if (byte_full_d) begin
                rx_valid_d  = 1'b1;
                rx_data_d   = byte_data_d;
                rx_status_d = byte_stat_d;
                byte_full_d = 1'b0;
                gap_d       = 8'(MIN_GAP - 1);
            end
        end
    end

    always_comb begin
        tcnt_d       = tcnt_q;
        fired_d      = fired_q;
        rx_timeout_d = 1'b0;
        if (!timeout_en) begin
            tcnt_d  = 16'd0;
            fired_d = 1'b0;
        end else if (rx_sop) begin
            tcnt_d = 16'd0;
        end else if (!fired_q) begin
            tcnt_d = tcnt_q + 16'd1;
            if (tcnt_d == TIMEOUT_CYCLES) begin
                rx_timeout_d = 1'b1;
                fired_d      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pid_q        <= 4'd0;
            crc_q        <= 16'hFFFF;
            bs_q         <= 1'b0;
            ovr_q        <= 1'b0;
            byte_full_q  <= 1'b0;
            byte_data_q  <= 8'd0;
            byte_stat_q  <= 8'd0;
            stop_full_q  <= 1'b0;
            stop_data_q  <= 8'd0;
            stop_first_q <= 1'b0;
            gap_q        <= 8'd0;
            rx_data_q    <= 8'd0;
            rx_status_q  <= 8'd0;
            rx_valid_q   <= 1'b0;
            rx_timeout_q <= 1'b0;
            tcnt_q       <= 16'd0;
            fired_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pid_q        <= pid_d;
            crc_q        <= crc_d;
            bs_q         <= bs_d;
            ovr_q        <= ovr_d;
            byte_full_q  <= byte_full_d;
            byte_data_q  <= byte_data_d;
            byte_stat_q  <= byte_stat_d;
            stop_full_q  <= stop_full_d;
            stop_data_q  <= stop_data_d;
            stop_first_q <= stop_first_d;
            gap_q        <= gap_d;
            rx_data_q    <= rx_data_d;
            rx_status_q  <= rx_status_d;
            rx_valid_q   <= rx_valid_d;
            rx_timeout_q <= rx_timeout_d;
            tcnt_q       <= tcnt_d;
            fired_q      <= fired_d;
        end
    end

    assign rx_data          = rx_data_q;
    assign rx_data_valid    = rx_valid_q;
    assign rx_stream_status = rx_status_q;
    assign rx_timeout       = rx_timeout_q;
endmodule

// File: doc/usb_slave_rx_stream_framer.md
Name: usb_slave_rx_stream_framer

Overview: Sits between the slave SIE's byte-level line receiver (NRZI decode, bit unstuff, deserialise) and the slave get-packet controller. Converts raw received bytes plus SOP/EOP/bit-stuff events into the tagged byte stream the get-packet controller consumes: PID byte, data bytes, then one stop/status byte. Checks PID integrity and CRC16 on data packets, and generates the single-cycle receive-timeout pulse.

Parameters:
TIMEOUT_CYCLES, 16'd1000, clk cycles from timeout_en assertion to rx_timeout pulse if no SOP arrives
MIN_GAP, 4, minimum clk cycles between successive rx_data_valid pulses (consumer needs ≥3)

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
rx_byte  input  8  received byte from line receiver
rx_byte_valid  input  1  one-cycle strobe, rx_byte valid
rx_sop  input  1  asserted together with rx_byte_valid on the first byte of a packet
rx_eop  input  1  one-cycle end-of-packet pulse
rx_bitstuff_err  input  1  one-cycle bit-stuff violation pulse
timeout_en  input  1  level; arms the timeout counter (driven by SIERxTimeOutEn)
rx_data  output  8  stream byte to get-packet controller
rx_data_valid  output  1  one-cycle strobe for rx_data/rx_stream_status
rx_stream_status  output  8  0 = PID byte, 1 = data byte, 2 = stop byte (rx_data carries flags)
rx_timeout  output  1  single-cycle timeout pulse

Behaviour:
- Reset: all outputs 0, FSM in IDLE, CRC reg 16'hFFFF, flags cleared, timeout counter 0, pending slots empty. rst mid-packet aborts the packet and emits no stop byte.
- FSM states: IDLE, PAYLOAD, DISCARD, STOP.
- IDLE: rx_byte_valid & rx_sop -> check rx_byte[7:4] == ~rx_byte[3:0]. Pass: queue rx_byte with status 0, latch PID, clear flags, CRC := FFFF, go PAYLOAD. Fail: go DISCARD, emit nothing. Bytes without SOP in IDLE are ignored.
- PAYLOAD: each rx_byte_valid queues the byte with status 1 (CRC bytes included) and updates CRC16 (poly 0x8005 reflected, LSB-first) when PID[1:0]==2'b11. rx_eop -> STOP. rx_sop in PAYLOAD is treated as a new packet: the current packet is closed with a stop byte (bit1 set) and the new PID is processed.
- DISCARD: ignore everything until rx_eop, then IDLE. No stream output.
- STOP: queue stop byte, return to IDLE. Stop flags: bit0 CRC error (data PID and residual != 16'h800D, else 0); bit1 bit-stuff error (any rx_bitstuff_err since SOP); bit2 PID==NAK (4'hA); bit3 internal overrun; bit5 PID==ACK (4'h2); bit6 PID==DATA1 (4'hB); other bits 0.
- rx_byte_valid and rx_eop in the same cycle: the byte is processed first, the stop byte follows it.
- Output scheduler: two-entry queue (byte slot plus stop slot). Latency from rx_byte_valid to rx_data_valid is 1 cycle when the gap counter permits. Consecutive rx_data_valid pulses are ≥MIN_GAP cycles apart; later items wait. A byte arriving while the byte slot is still full is dropped and sets overrun (bit3).
- rx_data and rx_stream_status hold their last values between strobes.
- Timeout: counter clears while timeout_en=0 or on rx_sop. While timeout_en=1 and not yet fired, it increments each cycle. At TIMEOUT_CYCLES it pulses rx_timeout for exactly 1 cycle and freezes until timeout_en drops. SOP in the same cycle as expiry suppresses the pulse.

Test Plan:
- DATA0 packet: SOP byte 0xC3, payload 0x01 0x02, then the valid CRC16 bytes, EOP -> stream (0xC3,0), (0x01,1), (0x02,1), (crc,1), (crc,1), (0x00,2); pulses spaced ≥4 cycles.
- DATA1 packet with one CRC byte corrupted plus one rx_bitstuff_err pulse -> stop byte 0x43 (bits 0, 1, 6).
- ACK handshake 0xD2 then EOP -> (0xD2,0), (0x20,2); NAK 0x5A -> (0x5A,0), (0x04,2).
- Bad PID 0xC2 with payload and EOP -> no rx_data_valid at all; next valid packet is framed normally.
- timeout_en held with no SOP -> rx_timeout high exactly at cycle TIMEOUT_CYCLES, single pulse. SOP at cycle 10 -> no pulse.
- Back-to-back rx_byte_valid on consecutive cycles, plus byte/EOP coincident -> second byte held until the gap elapses, third dropped with stop flag bit3 set. rst asserted mid-packet -> outputs 0, no stop byte.
